seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
- Parametrised, multi-cycle add/subtract unit for the calculator datapath.
- Generalises the fixed 8-bit ripple adder to WIDTH bits and to either add or subtract mode.
- Processes CHUNK bits per clock, LSB chunk first, under a start/done handshake, so wide operands cost cycles instead of a long carry chain.
- Reports carry/no-borrow, correct two's-complement signed overflow, and a zero flag.

Parameters:
WIDTH  8  operand/result width in bits; >= 2
CHUNK  1  bits added per clock; must divide WIDTH exactly; NCHUNK = WIDTH/CHUNK

Ports:
clk       input   1      rising-edge clock, the only clock
rst_n     input   1      synchronous, active-low reset
start     input   1      request; accepted only when busy=0
mode      input   1      0 = a+b, 1 = a-b; sampled with start
a         input   WIDTH  operand A; sampled with start
b         input   WIDTH  operand B; sampled with start
busy      output  1      operation in progress
done      output  1      one-cycle pulse: results updated this cycle
sum       output  WIDTH  result, registered
carry     output  1      add: carry-out; sub: 1 = no borrow (a >= b unsigned)
overflow  output  1      signed overflow of the operation
zero      output  1      sum == 0

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low. Reset is sampled on the clk rising edge only.
- Reset (rst_n=0 at an edge): state=IDLE.
  - busy=0, done=0, sum=0, carry=0, overflow=0, zero=0.
  - Internal operand/shift registers and chunk counter cleared.
- FSM states are IDLE and RUN.
- IDLE:
  - busy=0.
  - On an edge with start=1: latch a, mode, and b (or ~b when mode=1).
  - Initialise the internal carry to mode (the +1 of two's complement).
  - Set chunk counter=0 and go to RUN.
- RUN:
  - busy=1.
  - Each edge adds chunk [cnt*CHUNK +: CHUNK] of A and B' plus the internal carry.
  - Stores that partial sum chunk, updates the internal carry, and increments cnt.
  - Ignores start.
  - On the edge processing chunk NCHUNK-1, registers the results, pulses done=1 for the following cycle, and returns to IDLE.
- Result rules:
  - carry = carry out of the MSB.
  - overflow = (carry into MSB) XOR (carry out of MSB); equivalently, operand signs (after inversion for subtract) equal and result sign differs.
  - zero = (final sum == 0).
- Latency: start sampled at edge E0; done=1 and results valid after edge E0+NCHUNK (8 edges for defaults). busy is high from after E0 through E0+NCHUNK-1.
- sum/carry/overflow/zero hold the previous result throughout RUN. They change only in the done cycle and then hold until the next done or reset.
- done and busy are never both 1. done is high only in a cycle where the FSM is IDLE.
- Back-to-back: start asserted during the done cycle is accepted. Throughput is one operation per NCHUNK+1 cycles.
- Changes to a/b/mode after acceptance have no effect on the operation in flight.
- Reset mid-operation: operation abandoned, no done pulse, all outputs take reset values at that edge.
- CHUNK = WIDTH degenerates to a single-cycle RUN (done after E0+1).

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- Defined: when overflow=1, sum is clamped to the signed limit in the done cycle.
  - Positive overflow gives 0111..1; negative overflow gives 1000..0.
  - The sign used is the MSB of the non-inverted operand A.
  - carry and overflow are still reported unchanged; zero is computed on the clamped value.
- Undefined: sum wraps modulo 2^WIDTH. No saturation logic is present.

Test Plan:
- Reset then idle: hold rst_n=0 two cycles, then release with start=0 -> all outputs 0 and busy=0 for 10 cycles.
- Defaults, a=8'h7F, b=8'h01, mode=0 -> done exactly 8 edges after accept; sum=8'h80, carry=0, overflow=1, zero=0. With ADDSUB_SATURATE_EN, sum=8'h7F.
- Subtract a=8'h05, b=8'h05 -> sum=8'h00, carry=1, overflow=0, zero=1. Then a=8'h03, b=8'h05 -> sum=8'hFE, carry=0, overflow=0.
- Add a=8'hFF, b=8'h01 -> sum=8'h00, carry=1, overflow=0, zero=1. Toggle start and a during RUN -> no effect, single done pulse.
- Back-to-back: assert start in the done cycle with a=8'h80, b=8'h01, mode=1 -> accepted; next done 9 cycles after the first, sum=8'h7F, overflow=1, carry=1.
- WIDTH=16, CHUNK=4, a=16'h1234, b=16'h0FFF, mode=0 -> done after 4 edges, sum=16'h2233, carry=0. Pull rst_n low after 2 RUN edges -> no done, outputs 0, busy=0.

Source files
------------

// File: rtl/seq_addsub.sv
`default_nettype none
// seq_addsub: multi-cycle add/subtract that processes CHUNK bits per clock, LSB chunk first.
// Optional build macro ADDSUB_SATURATE_EN clamps an overflowing result to the signed limit.
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              cin_q, cin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [CHUNK:0]    w_psum;
  logic [WIDTH-1:0]  w_acc_next;
  logic [WIDTH-1:0]  w_res;
  logic              w_ovf;
  logic              w_last;

  // Operands shift right each RUN cycle, so the active chunk is always the low CHUNK bits
  // and, on the last chunk, bit CHUNK-1 is the original MSB.
  assign w_psum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin_q};
  assign w_acc_next = (acc_q >> CHUNK) | (WIDTH'(w_psum[CHUNK-1:0]) << (WIDTH - CHUNK));
  assign w_ovf      = (a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ w_psum[CHUNK-1]) ^ w_psum[CHUNK];
  assign w_last     = (cnt_q == CW'(NCHUNK - 1));

`ifdef ADDSUB_SATURATE_EN
  assign w_res = w_ovf ? {a_q[CHUNK-1], {(WIDTH-1){~a_q[CHUNK-1]}}} : w_acc_next;
`else
  assign w_res = w_acc_next;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = mode ? ~b : b;
          cin_d   = mode;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        acc_d = w_acc_next;
        cin_d = w_psum[CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (w_last) begin
          sum_d   = w_res;
          carry_d = w_psum[CHUNK];
          ovf_d   = w_ovf;
          zero_d  = (w_res == '0);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
// tb_seq_addsub: scoreboard bench for seq_addsub, default 8x1 build plus a 16x4 instance.
module tb_seq_addsub;

  typedef struct {
    logic [15:0] sum;
    logic        c;
    logic        o;
    logic        z;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, mode8, busy8, done8, carry8, ovf8, zero8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, mode16, busy16, done16, carry16, ovf16, zero16;
  logic [15:0] a16, b16, sum16;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic rst_seen = 1'b1;
  exp_t q8[$];
  exp_t last8;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= ~rst_n;
  end

  seq_addsub dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8), .zero(zero8)
  );

  seq_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .overflow(ovf16), .zero(zero16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: whole-word two's-complement arithmetic on a w-bit operand pair.
  function automatic exp_t model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                 input logic im);
    exp_t        e;
    logic [16:0] m17;
    logic [15:0] mask, bp, s;
    logic [16:0] full;
    m17  = (17'd1 << w) - 17'd1;
    mask = m17[15:0];
    bp   = (im ? ~ib : ib) & mask;
    full = {1'b0, ia & mask} + {1'b0, bp} + {16'd0, im};
    s    = full[15:0] & mask;
    e.c  = full[w];
    e.o  = (ia[w-1] == bp[w-1]) && (s[w-1] != ia[w-1]);
`ifdef ADDSUB_SATURATE_EN
    if (e.o) s = ia[w-1] ? (16'd1 << (w - 1)) : (mask >> 1);
`endif
    e.sum = s;
    e.z   = (s == 16'd0);
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_seen) begin
      q8.delete();
      last8 = '{16'd0, 1'b0, 1'b0, 1'b0, 0};
      check("rst8", {busy8, done8, sum8, carry8, ovf8, zero8}, 32'd0);
    end else if (done8) begin
      if (q8.size() == 0) begin
        check("spurious_done8", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("latency8", cyc, e.cyc);
        check("sum8", sum8, {24'd0, e.sum[7:0]});
        check("flags8", {carry8, ovf8, zero8}, {29'd0, e.c, e.o, e.z});
        check("done_busy8", busy8, 32'd0);
        last8 = e;
      end
    end else if (busy8) begin
      check("hold8", {sum8, carry8, ovf8, zero8}, {21'd0, last8.sum[7:0], last8.c, last8.o, last8.z});
    end
  end

  // Call at a negedge; waits for idle (the done cycle counts) then presents one request.
  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic im);
    exp_t e;
    int   g;
    g = 0;
    while (busy8 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (busy8) check("issue_timeout8", 32'd1, 32'd0);
    start8 = 1'b1;
    a8     = ia;
    b8     = ib;
    mode8  = im;
    e      = model(8, {8'd0, ia}, {8'd0, ib}, im);
    e.cyc  = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  initial begin
    exp_t e16;
    int   c0, g, seen;
    rst_n = 1'b0; start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle8", {busy8, done8, sum8, carry8, ovf8, zero8}, 32'd0);
    end

    issue8(8'h7F, 8'h01, 1'b0);
    repeat (10) @(negedge clk);
    issue8(8'h05, 8'h05, 1'b1);
    issue8(8'h03, 8'h05, 1'b1);
    issue8(8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      start8 = (i % 2 == 0);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      mode8  = 1'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    issue8(8'h80, 8'h01, 1'b1);
    for (int i = 0; i < 6; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    g = 0;
    while (q8.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain8", q8.size(), 32'd0);

    e16 = model(16, 16'h1234, 16'h0FFF, 1'b0);
    a16 = 16'h1234; b16 = 16'h0FFF; mode16 = 1'b0; start16 = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start16 = 1'b0;
    g = 0;
    while (!done16 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("done16_seen", done16, 32'd1);
    check("latency16", cyc, c0 + 5);
    check("sum16", sum16, {16'd0, e16.sum});
    check("flags16", {carry16, ovf16, zero16}, {29'd0, e16.c, e16.o, e16.z});
    check("done_busy16", busy16, 32'd0);

    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst16", {busy16, done16, sum16, carry16, ovf16, zero16}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done16) seen++;
    end
    check("no_done16", seen, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
